// File: rtl/lead_exp_normalizer.sv
// Iterative block-floating-point compressor: 32-bit signed word to an 8-bit
// mantissa and 5-bit exponent (value ~= mantissa * 2^(exponent-7)).
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; last result held on mantissa/exponent
// ST_SHIFT | one redundant-sign left shift per enabled cycle
// ST_ROUND | round top byte, form exponent, pulse done
module lead_exp_normalizer #(
  parameter int MAX_SHIFT = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkEn,
  input  logic        start,
  input  logic [31:0] dataIn,
  output logic        busy,
  output logic        done,
  output logic [7:0]  mantissa,
  output logic [4:0]  exponent
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;

  localparam logic [4:0] N_LAST = 5'(MAX_SHIFT);

  logic [1:0]  state_q, state_d;
  logic [31:0] y_q, y_d;
  logic [4:0]  n_q, n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  mant_q, mant_d;
  logic [4:0]  exp_q, exp_d;

  logic [7:0]  m_raw;
  logic        guard;
  logic [7:0]  m_rounded;
  logic        normalized;

  assign m_raw      = y_q[31:24];
  assign guard      = y_q[23];
  // Only +127 can overflow; a normalized negative top byte tops out at 8'hBF.
  assign m_rounded  = (guard && (m_raw != 8'h7F)) ? (m_raw + 8'd1) : m_raw;
  assign normalized = (y_q[31] != y_q[30]);

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    n_d     = n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mant_d  = mant_q;
    exp_d   = exp_q;

    if (clkEn) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            y_d     = dataIn;
            n_d     = 5'd0;
            busy_d  = 1'b1;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (normalized || (n_q == N_LAST)) begin
            state_d = ST_ROUND;
          end else begin
            y_d = {y_q[30:0], 1'b0};
            n_d = n_q + 5'd1;
          end
        end
        ST_ROUND: begin
          // Exhausting the shift budget means the input was 0 or -1.
          if (n_q == N_LAST) begin
            mant_d = 8'h00;
            exp_d  = 5'd0;
          end else begin
            mant_d = m_rounded;
            exp_d  = N_LAST - n_q;
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      y_q     <= 32'h0;
      n_q     <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mant_q  <= 8'h00;
      exp_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mantissa = mant_q;
  assign exponent = exp_q;

endmodule

// File: tb/tb_lead_exp_normalizer.sv
// Self-checking bench for lead_exp_normalizer: directed table, corner
// sequences (enable gating, start while busy, reset abort) and random data.
module tb_lead_exp_normalizer;

  logic        clk;
  logic        reset;
  logic        clkEn;
  logic        start;
  logic [31:0] dataIn;
  logic        busy;
  logic        done;
  logic [7:0]  mantissa;
  logic [4:0]  exponent;

  int checks = 0;
  int errors = 0;

  lead_exp_normalizer dut (
    .clk      (clk),
    .reset    (reset),
    .clkEn    (clkEn),
    .start    (start),
    .dataIn   (dataIn),
    .busy     (busy),
    .done     (done),
    .mantissa (mantissa),
    .exponent (exponent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  m;
    logic [4:0]  e;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: count redundant sign bits, shift, round half up, saturate +127.
  task automatic ref_model(input logic [31:0] d, output logic [7:0] m,
                           output logic [4:0] e, output int lat);
    int n;
    logic [31:0] y;
    int mr;
    n = 0;
    while (n < 31 && d[30-n] == d[31]) n++;
    y = d << n;
    lat = n + 2;
    if (n == 31) begin
      m = 8'h00;
      e = 5'd0;
    end else begin
      mr = $signed(y[31:24]);
      if (y[23]) mr = mr + 1;
      if (mr > 127) mr = 127;
      m = 8'(mr);
      e = 5'(31 - n);
    end
  endtask

  task automatic convert(input logic [31:0] d, input int period, input int inject,
                         output logic [7:0] m, output logic [4:0] e,
                         output int lat, output int pulses, output bit got);
    int after;
    got = 0; lat = 0; pulses = 0; after = 0; m = 8'h00; e = 5'd0;
    @(negedge clk);
    start = 1'b1; dataIn = d; clkEn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    for (int i = 0; i < 300 && after < 4; i++) begin
      clkEn = ((i % period) == 0);
      if (i == inject) begin
        start = 1'b1; dataIn = 32'h7FFFFFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      if (clkEn && !got) lat++;
      @(negedge clk);
      if (done) begin
        pulses++;
        if (!got) begin
          got = 1; m = mantissa; e = exponent;
        end
      end
      if (got) after++;
    end
    clkEn = 1'b1; start = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [31:0] d, input int period,
                           input int inject, input logic [7:0] em, input logic [4:0] ee,
                           input int elat);
    logic [7:0] m;
    logic [4:0] e;
    int lat, pulses;
    bit got;
    convert(d, period, inject, m, e, lat, pulses, got);
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout data=%08h no done seen", tag, d);
    end else begin
      chk({tag, "_mantissa"}, m, em);
      chk({tag, "_exponent"}, e, ee);
      chk({tag, "_latency"}, lat, elat);
      chk({tag, "_pulses"}, pulses, 1);
      chk({tag, "_busy_after"}, busy, 0);
    end
  endtask

  initial begin
    logic [7:0] rm;
    logic [4:0] re;
    int rlat;
    int sh, per, done_seen;
    logic [31:0] d;

    reset = 1'b0; clkEn = 1'b0; start = 1'b0; dataIn = 32'h0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_mantissa", mantissa, 0);
    chk("reset_exponent", exponent, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    vecs[0] = '{32'h12345678, 8'h49, 5'd29, 4};
    vecs[1] = '{32'h7FFFFFFF, 8'h7F, 5'd31, 2};
    vecs[2] = '{32'h80000000, 8'h80, 5'd31, 2};
    vecs[3] = '{32'h00000001, 8'h40, 5'd1, 32};
    vecs[4] = '{32'hFFFFF000, 8'h80, 5'd12, 21};
    vecs[5] = '{32'h00000000, 8'h00, 5'd0, 33};
    vecs[6] = '{32'hFFFFFFFF, 8'h00, 5'd0, 33};
    vecs[7] = '{32'hFFFFFFFE, 8'h80, 5'd1, 32};

    for (int i = 0; i < 8; i++)
      run_check($sformatf("vec%0d", i), vecs[i].data, 1, -1, vecs[i].m, vecs[i].e, vecs[i].lat);

    // Enable active one cycle in three; latency counts enabled edges only.
    run_check("gated", 32'h00000100, 3, -1, 8'h40, 5'd9, 24);

    // Second start while busy must be ignored.
    run_check("start_busy", 32'h00000100, 1, 5, 8'h40, 5'd9, 24);

    // Reset mid-SHIFT: outputs clear asynchronously, no done afterwards.
    @(negedge clk);
    start = 1'b1; dataIn = 32'h00000100; clkEn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_mantissa", mantissa, 0);
    chk("abort_exponent", exponent, 0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_busy_idle", busy, 0);
    chk("abort_mantissa_held", mantissa, 0);
    run_check("post_reset", 32'h12345678, 1, -1, 8'h49, 5'd29, 4);

    for (int k = 0; k < 60; k++) begin
      d = $urandom;
      sh = $urandom_range(0, 31);
      d = $signed(d) >>> sh;
      per = $urandom_range(1, 3);
      ref_model(d, rm, re, rlat);
      run_check($sformatf("rand%0d", k), d, per, -1, rm, re, rlat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lead_exp_normalizer.md
Name: lead_exp_normalizer

Overview:
Iterative block-floating-point compressor: the inverse of the lead-gain expander. It takes a 32-bit signed loop-filter word and produces an 8-bit signed mantissa plus a 5-bit exponent, using the same exponent convention, so that value ≈ mantissa·2^(exponent−7). It sits after loop integrators and feeds the telemetry/AGC readback path and gain-programming registers. Normalization shifts one bit per enabled cycle to keep timing trivial.

Parameters:
MAX_SHIFT, 31, maximum left shifts before the block forces the zero-exponent result; fixed by the 5-bit exponent.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
clkEn  input  1  clock enable; all state advances only when high
start  input  1  request; sampled only in IDLE with clkEn high
dataIn  input  32  signed value to compress; captured on the accepted start
busy  output  1  high from accepted start until done
done  output  1  one-clk pulse; mantissa/exponent valid and held from this cycle
mantissa  output  8  signed normalized mantissa
exponent  output  5  exponent, leadGain convention (0 = zero output)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, mantissa=8'h00, exponent=5'h00; shift register and counter cleared. Reset mid-operation aborts with no done.
- clkEn=0: FSM, shift register, counter and outputs hold. done is forced to 0 on every clk where it is not being set.
- IDLE: on clkEn & start: y<=dataIn, n<=0, busy<=1, go to SHIFT. start while busy is ignored, with no queuing.
- SHIFT, per clkEn cycle:
  - If y[31]!=y[30] or n==31: go to ROUND.
  - Otherwise y<=y<<1 with a zero fill, and n<=n+1.
- ROUND, single clkEn cycle:
  - m_raw=y[31:24], guard=y[23], e=31−n.
  - mantissa <= (guard && m_raw!=8'h7F) ? m_raw+1 : m_raw. This is round-half-up, saturating only at +127. A normalized negative m_raw is at most 8'hBF, so it cannot wrap.
  - If e==0 (n==31, covers dataIn=0 and dataIn=−1): mantissa<=0 and exponent<=0.
  - Otherwise exponent<=e.
  - done<=1 for one clk, busy<=0, go to IDLE.
- Latency: with final shift count n, done rises on the (n+2)th clkEn edge after the start-accept edge. Minimum is 2 (already normalized); maximum is 33 (n=31).
- Outputs hold their last result until the next done or reset. A new start is accepted on the clkEn edge after done (IDLE).
- Redundant-sign rule: n = number of bits in dataIn[30:0], counted from bit 30 down, equal to dataIn[31] before the first differing bit (max 31).

Test Plan:
- dataIn=32'h12345678: n=2, m_raw=8'h48, guard=1 → mantissa=8'h49, exponent=5'd29, done on the 4th clkEn edge after start.
- dataIn=32'h7FFFFFFF: n=0, guard=1 but saturate → mantissa=8'h7F, exponent=31, latency 2. dataIn=32'h80000000 → mantissa=8'h80, exponent=31.
- dataIn=32'h00000001 → mantissa=8'h40, exponent=1, latency 32. dataIn=32'hFFFFF000 → mantissa=8'h80, exponent=12, latency 21.
- dataIn=0 and dataIn=32'hFFFFFFFF → mantissa=0, exponent=0, latency 33, exactly one done pulse each.
- clkEn toggled 1-of-3 during a 32'h00000100 conversion → same result (8'h40, exponent 9). Latency is counted in enabled edges only; done is exactly one clk wide.
- start pulsed while busy, then reset asserted mid-SHIFT → second start ignored. On reset: outputs 0, busy 0, no done. After release, a fresh start converts normally.
